rotary_quad_decoder: RTL and testbench

Upstream stage for one rotary encoder. It takes the raw two-bit quadrature input from the encoder pins and produces debounced single-cycle clockwise and counter-clockwise event pulses. It also keeps an 8-bit position count that drives the eight-bit-to-seven-segment display stage directly. One instance is used per encoder in the rotary/hex display system.

---
 rtl/rotary_pkg.sv | 6 +
 rtl/rotary_debounce.sv | 37 +++
 rtl/rotary_quad_decoder.sv | 82 ++++++++
 tb/tb_rotary_quad_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// rotary_pkg: shared state type and constants for the rotary encoder decoder
package rotary_pkg;
  localparam int POS_W = 8;
  localparam logic [1:0] DETENT = 2'b11;
  typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC} rot_state_e;
endpackage

// File: rtl/rotary_debounce.sv
// rotary_debounce: two-flop synchroniser plus stability counter for one encoder pin
module rotary_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic deb_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic meta_q, sync_q, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mismatch, hit;
  // accept the new level once it has disagreed for DEBOUNCE_CYCLES consecutive samples
  always_comb begin
    mismatch = sync_q != deb_q;
    hit = mismatch && cnt_q == LAST;
    cnt_d = (!mismatch || hit) ? '0 : cnt_q + 1'b1;
    deb_d = hit ? sync_q : deb_q;
  end
  // synchroniser, counter and debounced level, idling at the detent level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  assign deb_o = deb_q;
endmodule

// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: debounced quadrature decode into cw/ccw pulses and a position count
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit WRAP = 1'b1,
  parameter int MAX_POS = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       rotary_in,
  input  logic             clear,
  output logic             rotary_cw,
  output logic             rotary_ccw,
  output logic [POS_W-1:0] position
);
  localparam logic [POS_W-1:0] MAX = POS_W'(MAX_POS);
  logic [1:0] deb, prev_q;
  rot_state_e state_q, state_d;
  logic cw_q, cw_d, ccw_q, ccw_d;
  logic [POS_W-1:0] pos_q, pos_d, inc, dec;
  for (genvar b = 0; b < 2; b++) begin : g_bit
    rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .reset_n(reset_n),
      .raw_i(rotary_in[b]),
      .deb_o(deb[b])
    );
  end
  // walk the quadrature cycle on each debounced change; a both-bits jump forces resync
  always_comb begin
    state_d = state_q;
    cw_d = 1'b0;
    ccw_d = 1'b0;
    if (state_q == RESYNC) state_d = deb == DETENT ? IDLE : RESYNC;
    else if (deb != prev_q) begin
      if ((deb ^ prev_q) == 2'b11) state_d = RESYNC;
      else
        case (state_q)
          IDLE: state_d = deb == 2'b01 ? CW1 : CCW1;
          CW1: state_d = deb == 2'b00 ? CW2 : IDLE;
          CW2: state_d = deb == 2'b10 ? CW3 : CW1;
          CW3: begin
            state_d = deb == DETENT ? IDLE : CW2;
            cw_d = deb == DETENT;
          end
          CCW1: state_d = deb == 2'b00 ? CCW2 : IDLE;
          CCW2: state_d = deb == 2'b01 ? CCW3 : CCW1;
          CCW3: begin
            state_d = deb == DETENT ? IDLE : CCW2;
            ccw_d = deb == DETENT;
          end
          default: state_d = RESYNC;
        endcase
    end
  end
  // position steps with the pulse, wrapping or saturating at the ends; clear wins
  always_comb begin
    inc = pos_q == MAX ? (WRAP ? '0 : MAX) : pos_q + 1'b1;
    dec = pos_q == '0 ? (WRAP ? MAX : '0) : pos_q - 1'b1;
    pos_d = clear ? '0 : cw_d ? inc : ccw_d ? dec : pos_q;
  end
  // state, last debounced value, registered pulses and position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prev_q <= DETENT;
      cw_q <= 1'b0;
      ccw_q <= 1'b0;
      pos_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= deb;
      cw_q <= cw_d;
      ccw_q <= ccw_d;
      pos_q <= pos_d;
    end
  end
  assign rotary_cw = cw_q;
  assign rotary_ccw = ccw_q;
  assign position = pos_q;
endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb_rotary_quad_decoder: wrap and saturate instances checked against a phase-travel model
module tb_rotary_quad_decoder;
  localparam int D = 4;
  localparam int MAXP = 255;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
  logic [1:0] rin = 2'b11;
  logic cw_w, ccw_w, cw_s, ccw_s;
  logic [7:0] pos_w, pos_s;
  int checks = 0, failures = 0, n_cw = 0, n_ccw = 0;
  bit started = 1'b0;
  logic [1:0] cws [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] ccws [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

  always #5 clk = ~clk;

  rotary_quad_decoder #(.DEBOUNCE_CYCLES(D), .WRAP(1'b1), .MAX_POS(MAXP)) dut_w (
    .clk(clk), .reset_n(reset_n), .rotary_in(rin), .clear(clear),
    .rotary_cw(cw_w), .rotary_ccw(ccw_w), .position(pos_w));
  rotary_quad_decoder #(.DEBOUNCE_CYCLES(D), .WRAP(1'b0), .MAX_POS(MAXP)) dut_s (
    .clk(clk), .reset_n(reset_n), .rotary_in(rin), .clear(clear),
    .rotary_cw(cw_s), .rotary_ccw(ccw_s), .position(pos_s));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int phase(input logic [1:0] v);
    return v == 2'b11 ? 0 : v == 2'b01 ? 1 : v == 2'b00 ? 2 : 3;
  endfunction

  logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_deb = 2'b11, m_prev = 2'b11, nd;
  logic [1:0] hist [D];
  int m_trav = 0, m_pw = 0, m_ps = 0;
  bit m_rs = 1'b0, m_cw = 1'b0, m_ccw = 1'b0, all_diff;

  always begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_prev = 2'b11;
      for (int i = 0; i < D; i++) hist[i] = 2'b11;
      m_trav = 0; m_rs = 0; m_cw = 0; m_ccw = 0; m_pw = 0; m_ps = 0;
    end else begin
      m_cw = 0;
      m_ccw = 0;
      if (m_rs) begin
        if (m_deb == 2'b11) begin m_rs = 0; m_trav = 0; end
      end else if (m_deb != m_prev) begin
        if ((m_deb ^ m_prev) == 2'b11) begin m_rs = 1; m_trav = 0; end
        else begin
          m_trav += (((phase(m_deb) - phase(m_prev)) & 3) == 1) ? 1 : -1;
          if (m_trav == 4) begin m_cw = 1; m_trav = 0; end
          if (m_trav == -4) begin m_ccw = 1; m_trav = 0; end
        end
      end
      if (clear) begin m_pw = 0; m_ps = 0; end
      else if (m_cw) begin m_pw = (m_pw + 1) % (MAXP + 1); m_ps = m_ps < MAXP ? m_ps + 1 : MAXP; end
      else if (m_ccw) begin m_pw = (m_pw + MAXP) % (MAXP + 1); m_ps = m_ps > 0 ? m_ps - 1 : 0; end
      m_prev = m_deb;
      for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_s2;
      nd = m_deb;
      for (int b = 0; b < 2; b++) begin
        all_diff = 1;
        for (int i = 0; i < D; i++) if (hist[i][b] == m_deb[b]) all_diff = 0;
        if (all_diff) nd[b] = ~m_deb[b];
      end
      m_deb = nd;
      m_s2 = m_s1;
      m_s1 = rin;
    end
  end

  always @(negedge clk) begin
    if (cw_w) n_cw++;
    if (ccw_w) n_ccw++;
    if (started) begin
      chk("cw_w", int'(cw_w), int'(m_cw));
      chk("ccw_w", int'(ccw_w), int'(m_ccw));
      chk("pos_w", int'(pos_w), m_pw);
      chk("cw_s", int'(cw_s), int'(m_cw));
      chk("ccw_s", int'(ccw_s), int'(m_ccw));
      chk("pos_s", int'(pos_s), m_ps);
      chk("excl", int'(cw_w & ccw_w), 0);
    end
  end

  task automatic step(input logic [1:0] v, input int hold);
    rin = v;
    repeat (hold) @(negedge clk);
  endtask

  task automatic detent(input bit dir, input int hold);
    for (int i = 0; i < 4; i++) step(dir ? cws[i] : ccws[i], hold);
  endtask

  int first, c0, a0, r;
  logic [1:0] v;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pos", int'(pos_w), 0);
    chk("rst_cw", int'(cw_w), 0);
    chk("rst_ccw", int'(ccw_w), 0);
    reset_n = 1'b1;
    started = 1'b1;
    repeat (3) @(negedge clk);
    step(2'b01, 10); step(2'b00, 10); step(2'b10, 10);
    rin = 2'b11;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cw_w && first == 0) first = i;
    end
    chk("cw_latency", first, 7);
    chk("cw_count", n_cw, 1);
    chk("cw_no_ccw", n_ccw, 0);
    chk("cw_pos", int'(pos_w), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_pos", int'(pos_w), 0);
    detent(1'b0, 10);
    repeat (5) @(negedge clk);
    chk("ccw_count", n_ccw, 1);
    chk("ccw_wrap", int'(pos_w), 255);
    chk("ccw_sat", int'(pos_s), 0);
    c0 = n_cw; a0 = n_ccw;
    step(2'b01, 3); step(2'b11, 15);
    step(2'b01, 6); step(2'b11, 15);
    chk("glitch_cw", n_cw - c0, 0);
    chk("glitch_ccw", n_ccw - a0, 0);
    chk("glitch_pos", int'(pos_w), 255);
    step(2'b01, 10); step(2'b00, 10); step(2'b01, 10); step(2'b11, 15);
    chk("back_cw", n_cw - c0, 0);
    detent(1'b0, 10);
    repeat (5) @(negedge clk);
    chk("back_ccw", n_ccw - a0, 1);
    chk("back_pos", int'(pos_w), 254);
    step(2'b00, 10); step(2'b01, 10); step(2'b11, 15);
    chk("illegal_cw", n_cw - c0, 0);
    detent(1'b1, 10);
    repeat (5) @(negedge clk);
    chk("after_illegal_cw", n_cw - c0, 1);
    chk("after_illegal_pos", int'(pos_s), 1);
    step(2'b01, 10); step(2'b00, 10); step(2'b10, 10);
    rin = 2'b11;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_pulse", int'(cw_s), 1);
    chk("clr_pos", int'(pos_s), 0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 254; i++) detent(1'b1, 6);
    repeat (5) @(negedge clk);
    chk("sat_254", int'(pos_s), 254);
    for (int i = 0; i < 3; i++) detent(1'b1, 6);
    repeat (5) @(negedge clk);
    chk("sat_255", int'(pos_s), 255);
    chk("wrap_257", int'(pos_w), 1);
    c0 = n_cw;
    step(2'b01, 10); step(2'b00, 10);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pos", int'(pos_w), 0);
    chk("async_pos_s", int'(pos_s), 0);
    chk("async_cw", int'(cw_w), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2'b10, 10); step(2'b11, 15);
    chk("reset_mid_cw", n_cw - c0, 0);
    chk("reset_mid_pos", int'(pos_w), 0);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      v = r < 8 ? rin ^ ((r % 2) ? 2'b01 : 2'b10) : 2'($urandom_range(0, 3));
      clear = $urandom_range(0, 99) < 3;
      rin = v;
      @(negedge clk);
      clear = 1'b0;
      repeat ($urandom_range(0, 11)) @(negedge clk);
    end
    step(2'b11, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
